ultrasonic_ranger: RTL

ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

---
 rtl/ranger_pkg.sv | 31 +++
 rtl/echo_sync.sv | 28 ++
 rtl/ultrasonic_ranger.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ranger_pkg.sv
// Shared definitions for the ultrasonic ranger: FSM encoding, default timing, no-echo code.
// RANGER_MEDIAN_EN (see ultrasonic_ranger) uses median3 below.
package ranger_pkg;

  localparam int unsigned TRIG_CYC_DEF    = 500;
  localparam int unsigned PERIOD_CYC_DEF  = 3000000;
  localparam int unsigned TIMEOUT_CYC_DEF = 1500000;

  // All-ones reads downstream as "no obstacle in range".
  localparam logic [31:0] NO_ECHO = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StHoldoff
  } state_e;

  function automatic logic [31:0] median3(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    if ((a >= b && a <= c) || (a <= b && a >= c)) begin
      return a;
    end else if ((b >= a && b <= c) || (b <= a && b >= c)) begin
      return b;
    end else begin
      return c;
    end
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the sensor echo plus edge detection on the synchronized value.
module echo_sync (
  input  logic osc,
  input  logic reset_n,
  input  logic echo,
  output logic echo_s,
  output logic rise,
  output logic fall
);

  // [0],[1]: synchronizer stages, [2]: previous synchronized sample
  logic [2:0] sync_q;

  always_ff @(posedge osc) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], echo};
    end
  end

  always_comb begin
    echo_s = sync_q[1];
    rise   = sync_q[1] & ~sync_q[2];
    fall   = ~sync_q[1] & sync_q[2];
  end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic range finder: periodic trigger, echo width measurement with timeout.
// Define RANGER_MEDIAN_EN to report the median of the last three raw results.
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int unsigned TRIG_CYC    = TRIG_CYC_DEF,
  parameter int unsigned PERIOD_CYC  = PERIOD_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        osc,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [31:0] echo_cnt,
  output logic        cnt_valid,
  output logic        timeout
);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;        // cycles spent in TRIG / WAIT_RISE
  logic [31:0] width_q, width_d;
  logic [31:0] period_q, period_d;
  logic [31:0] echo_cnt_q;
  logic        cnt_valid_q;
  logic        timeout_q;

  logic        echo_s, rise, fall;
  logic        res_valid, res_timeout;
  logic [31:0] res_val, res_filt;

  echo_sync u_echo_sync (
    .osc    (osc),
    .reset_n(reset_n),
    .echo   (echo),
    .echo_s (echo_s),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge osc) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      width_q     <= '0;
      period_q    <= '0;
      echo_cnt_q  <= NO_ECHO;
      cnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      period_q    <= period_d;
      cnt_valid_q <= res_valid;
      if (res_valid) begin
        echo_cnt_q <= res_filt;
        timeout_q  <= res_timeout;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    width_d     = width_q;
    // Saturates so an overrunning measurement releases HOLDOFF at once.
    period_d    = (period_q == PERIOD_CYC - 1) ? period_q : period_q + 32'd1;
    res_valid   = 1'b0;
    res_timeout = 1'b0;
    res_val     = NO_ECHO;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable) begin
          state_d  = StTrig;
          period_d = '0;
        end
      end
      StTrig: begin
        if (cnt_q == TRIG_CYC - 1) begin
          state_d = StWaitRise;
          cnt_d   = '0;
        end
      end
      StWaitRise: begin
        if (rise) begin
          // The rise cycle is itself the first high cycle of the pulse.
          state_d = StMeasure;
          width_d = 32'd1;
        end else if (cnt_q == TIMEOUT_CYC - 1) begin
          state_d     = StHoldoff;
          res_valid   = 1'b1;
          res_timeout = 1'b1;
        end
      end
      StMeasure: begin
        if (fall) begin
          state_d   = StHoldoff;
          res_valid = 1'b1;
          res_val   = width_q;
        end else if (width_q == TIMEOUT_CYC) begin
          state_d     = StHoldoff;
          res_valid   = 1'b1;
          res_timeout = 1'b1;
        end else if (echo_s) begin
          width_d = width_q + 32'd1;
        end
      end
      StHoldoff: begin
        if (period_q == PERIOD_CYC - 1) begin
          if (enable) begin
            state_d  = StTrig;
            cnt_d    = '0;
            period_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef RANGER_MEDIAN_EN
  logic [31:0] hist_q [2];

  always_ff @(posedge osc) begin
    if (!reset_n) begin
      hist_q[0] <= NO_ECHO;
      hist_q[1] <= NO_ECHO;
    end else if (res_valid) begin
      hist_q[0] <= res_val;
      hist_q[1] <= hist_q[0];
    end
  end

  always_comb begin
    res_filt = median3(res_val, hist_q[0], hist_q[1]);
  end
`else
  always_comb begin
    res_filt = res_val;
  end
`endif

  always_comb begin
    trig      = (state_q == StTrig);
    echo_cnt  = echo_cnt_q;
    cnt_valid = cnt_valid_q;
    timeout   = timeout_q;
  end

endmodule
